// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes the ALU op, forwards operands, and registers them for EX.
// Detects load-use stalls and resolves BEQ/JAL flushes from the EX zero flag.
module alu_issue_stage #(
   parameter int DATA_W = 8,
   parameter int RIDX_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [1:0]        id_opclass,
   input  logic [2:0]        id_funct3,
   input  logic              id_funct7b5,
   input  logic [RIDX_W-1:0] id_rs1,
   input  logic [RIDX_W-1:0] id_rs2,
   input  logic [RIDX_W-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic [RIDX_W-1:0] mem_rd,
   input  logic              mem_reg_write,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [RIDX_W-1:0] wb_rd,
   input  logic              wb_reg_write,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic [3:0]        ALU_control,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [RIDX_W-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              stall,
   output logic              flush,
   output logic [DATA_W-1:0] branch_target,
   output logic              illegal_op
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOT  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_JUMP = 4'b1100;

   localparam logic [1:0] CLS_R   = 2'b00;
   localparam logic [1:0] CLS_I   = 2'b01;
   localparam logic [1:0] CLS_BEQ = 2'b10;
   localparam logic [1:0] CLS_JAL = 2'b11;

   logic [3:0]        dec_ctrl;
   logic              dec_illegal;
   logic              use_rs2;
   logic              hazard;
   logic              issue;
   logic              ex_is_beq;
   logic              ex_is_jal;
   logic [RIDX_W-1:0] src_idx [2];
   logic [DATA_W-1:0] rf_dat  [2];
   logic [DATA_W-1:0] fwd_dat [2];
   logic [DATA_W-1:0] op2_sel;

   always_comb begin
      dec_ctrl    = OP_ADD;
      dec_illegal = 1'b0;
      case (id_opclass)
         CLS_R, CLS_I: begin
            case (id_funct3)
               3'b000:  dec_ctrl = (id_opclass == CLS_R && id_funct7b5) ? OP_SUB : OP_ADD;
               3'b111:  dec_ctrl = OP_AND;
               3'b110:  dec_ctrl = OP_OR;
               3'b100:  dec_ctrl = OP_XOR;
               3'b101:  dec_ctrl = OP_NOT;
               default: dec_illegal = 1'b1;
            endcase
         end
         CLS_BEQ: dec_ctrl = OP_SUB;
         default: dec_ctrl = OP_JUMP;
      endcase
   end

   // A load in EX has no result yet, so it is excluded from the EX bypass.
   always_comb begin
      src_idx[0] = id_rs1;
      src_idx[1] = id_rs2;
      rf_dat[0]  = id_rs1_data;
      rf_dat[1]  = id_rs2_data;
      for (int i = 0; i < 2; i++) begin
         if (src_idx[i] == '0)
            fwd_dat[i] = '0;
         else if (ex_valid && ex_reg_write && !ex_mem_read && ex_rd == src_idx[i])
            fwd_dat[i] = alu_result;
         else if (mem_reg_write && mem_rd == src_idx[i])
            fwd_dat[i] = mem_result;
         else if (wb_reg_write && wb_rd == src_idx[i])
            fwd_dat[i] = wb_result;
         else
            fwd_dat[i] = rf_dat[i];
      end
   end

   always_comb begin
      op2_sel = fwd_dat[1];
      if (id_opclass == CLS_I)
         op2_sel = id_imm;
      else if (id_opclass == CLS_JAL)
         op2_sel = '0;
   end

   assign use_rs2 = (id_opclass == CLS_R) || (id_opclass == CLS_BEQ);
   assign hazard  = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (use_rs2 && ex_rd == id_rs2));
   assign flush   = ex_valid && ((ex_is_beq && alu_zero) || ex_is_jal);
   assign stall   = hazard && !flush;
   assign issue   = id_valid && !flush && !hazard && !dec_illegal;

   // Bubbles clear only the control bits; the operand registers keep their last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data1         <= '0;
         data2         <= '0;
         ALU_control   <= OP_AND;
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_rd         <= '0;
         ex_store_data <= '0;
         branch_target <= '0;
         illegal_op    <= 1'b0;
         ex_is_beq     <= 1'b0;
         ex_is_jal     <= 1'b0;
      end else begin
         ex_valid     <= issue;
         ex_reg_write <= issue && id_reg_write;
         ex_mem_read  <= issue && id_mem_read;
         ex_is_beq    <= issue && (id_opclass == CLS_BEQ);
         ex_is_jal    <= issue && (id_opclass == CLS_JAL);
         illegal_op   <= id_valid && !flush && !hazard && dec_illegal;
         if (issue) begin
            data1         <= fwd_dat[0];
            data2         <= op2_sel;
            ALU_control   <= dec_ctrl;
            ex_rd         <= id_rd;
            ex_store_data <= fwd_dat[1];
            branch_target <= id_pc + id_imm;
         end
      end
   end

endmodule
